// File: rtl/store_align_buffer.sv
// Store alignment and write buffer: lane-aligns masked store data, builds byte
// enables, queues stores in a small FIFO and drains them over a req/ack port.
module store_align_buffer #(
    parameter int         DEPTH = 2,
    parameter logic [5:0] SB_OP = 6'h28,
    parameter logic [5:0] SH_OP = 6'h29,
    parameter logic [5:0] SW_OP = 6'h2B
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StoreValid,
    input  logic [5:0]  Opcode,
    input  logic [31:0] Addr,
    input  logic [31:0] DataInMasked,
    output logic        StoreStall,
    output logic        AlignErr,
    output logic        BufEmpty,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    output logic [31:0] MemWrData,
    output logic [3:0]  MemWE,
    input  logic        MemAck
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic {
        S_IDLE,
        S_REQ
    } state_t;

    typedef struct packed {
        logic [29:0] waddr;
        logic [31:0] data;
        logic [3:0]  we;
    } entry_t;

    entry_t             fifo_q [DEPTH];
    entry_t             fifo_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    state_t             state_q, state_d;
    logic               align_err_q, align_err_d;

    logic               is_store;
    logic               misaligned;
    logic [1:0]         off;
    logic [4:0]         shamt;
    logic [31:0]        algn_data;
    logic [3:0]         algn_we;
    logic [31:0]        lane_mask;
    entry_t             new_entry;
    entry_t             head;
    logic               stall;
    logic               push;
    logic               pop;

    // Big-endian lanes: offset 0 is bits [31:24], so data shifts right with offset.
    always_comb begin
        off        = Addr[1:0];
        shamt      = {off, 3'b000};
        is_store   = StoreValid && ((Opcode == SB_OP) || (Opcode == SH_OP) || (Opcode == SW_OP));
        misaligned = 1'b0;
        algn_data  = '0;
        algn_we    = '0;
        if (Opcode == SB_OP) begin
            algn_we   = 4'b1000 >> off;
            algn_data = DataInMasked >> shamt;
        end else if (Opcode == SH_OP) begin
            if (off[0]) begin
                misaligned = 1'b1;
            end else if (off[1]) begin
                algn_we   = 4'b0011;
                algn_data = DataInMasked >> 16;
            end else begin
                algn_we   = 4'b1100;
                algn_data = DataInMasked;
            end
        end else if (Opcode == SW_OP) begin
            if (off != 2'b00) begin
                misaligned = 1'b1;
            end else begin
                algn_we   = 4'b1111;
                algn_data = DataInMasked;
            end
        end
        lane_mask = {{8{algn_we[3]}}, {8{algn_we[2]}}, {8{algn_we[1]}}, {8{algn_we[0]}}};
        new_entry.waddr = Addr[31:2];
        new_entry.data  = algn_data & lane_mask;
        new_entry.we    = algn_we;
    end

    // Stall uses the registered count only, so a same-cycle pop never frees a slot.
    assign stall = (count_q == FULL_CNT);
    assign push  = is_store && !stall && !misaligned;
    assign pop   = (state_q == S_REQ) && MemAck;
    assign head  = fifo_q[rd_ptr_q];

    always_comb begin
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        state_d     = state_q;
        align_err_d = is_store && !stall && misaligned;

        if (push) begin
            fifo_d[wr_ptr_q] = new_entry;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // Looking at the post-edge count lets a push into an empty buffer request next cycle.
        case (state_q)
            S_IDLE: begin
                if (count_d != '0) begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (pop && (count_d == '0)) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= S_IDLE;
            align_err_q <= 1'b0;
        end else begin
            fifo_q      <= fifo_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            align_err_q <= align_err_d;
        end
    end

    assign StoreStall = stall;
    assign AlignErr   = align_err_q;
    assign BufEmpty   = (count_q == '0) && (state_q == S_IDLE);
    assign MemReq     = (state_q == S_REQ);
    assign MemAddr    = MemReq ? {head.waddr, 2'b00} : '0;
    assign MemWrData  = MemReq ? head.data : '0;
    assign MemWE      = MemReq ? head.we : '0;

endmodule

// File: tb/tb_store_align_buffer.sv
// Bench for store_align_buffer: directed literal scenarios plus randomized traffic
// compared every cycle against a queue-based model of the store buffer.
module tb_store_align_buffer;

    localparam int         DEPTH = 2;
    localparam logic [5:0] SB = 6'h28;
    localparam logic [5:0] SH = 6'h29;
    localparam logic [5:0] SW = 6'h2B;

    logic        clk = 1'b0;
    logic        rst;
    logic        StoreValid;
    logic [5:0]  Opcode;
    logic [31:0] Addr;
    logic [31:0] DataInMasked;
    logic        StoreStall;
    logic        AlignErr;
    logic        BufEmpty;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic [31:0] MemWrData;
    logic [3:0]  MemWE;
    logic        MemAck;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  we;
    } ent_t;

    ent_t mq[$];
    ent_t wlog[$];
    bit   m_err   = 1'b0;
    bit   started = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;

    store_align_buffer #(.DEPTH(DEPTH), .SB_OP(SB), .SH_OP(SH), .SW_OP(SW)) dut (
        .clk(clk), .rst(rst), .StoreValid(StoreValid), .Opcode(Opcode), .Addr(Addr),
        .DataInMasked(DataInMasked), .StoreStall(StoreStall), .AlignErr(AlignErr),
        .BufEmpty(BufEmpty), .MemReq(MemReq), .MemAddr(MemAddr), .MemWrData(MemWrData),
        .MemWE(MemWE), .MemAck(MemAck)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model alignment: take the byte/half from the top of the word and place it in its lane.
    function automatic bit model_align(input logic [5:0] op, input logic [31:0] a,
                                       input logic [31:0] d, output ent_t e);
        int off;
        off  = int'(a[1:0]);
        e.a  = a & 32'hFFFF_FFFC;
        e.d  = '0;
        e.we = '0;
        if (op == SB) begin
            e.we = 4'(1 << (3 - off));
            e.d  = {24'h0, d[31:24]} << (8 * (3 - off));
            return 1'b1;
        end else if (op == SH) begin
            if (off % 2 != 0) return 1'b0;
            e.we = (off == 0) ? 4'b1100 : 4'b0011;
            e.d  = {16'h0, d[31:16]} << ((off == 0) ? 16 : 0);
            return 1'b1;
        end else begin
            if (off != 0) return 1'b0;
            e.we = 4'b1111;
            e.d  = d;
            return 1'b1;
        end
    endfunction

    always @(posedge clk) begin
        ent_t e;
        bit   ok;
        bit   full;
        bit   do_pop;
        bit   st;
        if (rst) begin
            mq.delete();
            m_err   = 1'b0;
            started = 1'b1;
        end else if (started) begin
            full   = (mq.size() == DEPTH);
            do_pop = (mq.size() > 0) && MemAck;
            st     = StoreValid && (Opcode == SB || Opcode == SH || Opcode == SW);
            ok     = model_align(Opcode, Addr, DataInMasked, e);
            m_err  = st && !full && !ok;
            if (do_pop) void'(mq.pop_front());
            if (st && !full && ok) mq.push_back(e);
        end
    end

    always @(posedge clk) begin
        if (started && !rst && MemReq === 1'b1 && MemAck === 1'b1)
            wlog.push_back('{a: MemAddr, d: MemWrData, we: MemWE});
    end

    always @(negedge clk) begin
        if (started) begin
            chk("stall", 32'(StoreStall), 32'(mq.size() == DEPTH));
            chk("align_err", 32'(AlignErr), 32'(m_err));
            chk("buf_empty", 32'(BufEmpty), 32'(mq.size() == 0));
            chk("mem_req", 32'(MemReq), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                chk("mem_addr", MemAddr, mq[0].a);
                chk("mem_data", MemWrData, mq[0].d);
                chk("mem_we", 32'(MemWE), 32'(mq[0].we));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic store(input logic [5:0] op, input logic [31:0] a, input logic [31:0] d);
        StoreValid   = 1'b1;
        Opcode       = op;
        Addr         = a;
        DataInMasked = d;
        step();
    endtask

    task automatic wait_writes(input int n, input string name);
        for (int k = 0; k < 40 && wlog.size() < n; k++) step();
        chk(name, 32'(wlog.size()), 32'(n));
    endtask

    initial begin
        logic [3:0]  sb_we[4];
        logic [31:0] sb_d[4];
        ent_t        me;
        int          errs;
        bit          req_seen;
        bit          ne_seen;
        int          ack_pct;

        sb_we = '{4'h8, 4'h4, 4'h2, 4'h1};
        sb_d  = '{32'hAB000000, 32'h00AB0000, 32'h0000AB00, 32'h000000AB};

        rst = 1'b1; StoreValid = 1'b0; Opcode = '0; Addr = '0; DataInMasked = '0; MemAck = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_stall", 32'(StoreStall), 32'd0);
        chk("rst_alignerr", 32'(AlignErr), 32'd0);
        chk("rst_bufempty", 32'(BufEmpty), 32'd1);
        chk("rst_memreq", 32'(MemReq), 32'd0);
        chk("rst_memaddr", MemAddr, 32'd0);
        chk("rst_memdata", MemWrData, 32'd0);
        chk("rst_memwe", 32'(MemWE), 32'd0);

        void'(model_align(SB, 32'h102, 32'hAB000000, me));
        chk("model_sb2_data", me.d, 32'h0000AB00);
        chk("model_sb2_we", 32'(me.we), 32'h2);
        void'(model_align(SH, 32'h202, 32'hBEEF0000, me));
        chk("model_sh2_data", me.d, 32'h0000BEEF);

        // SB sweep
        MemAck = 1'b1;
        wlog.delete();
        for (int i = 0; i < 4; i++) store(SB, 32'h100 + i, 32'hAB000000);
        StoreValid = 1'b0;
        wait_writes(4, "sb_write_count");
        if (wlog.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("sb_addr", wlog[i].a, 32'h100);
                chk("sb_we", 32'(wlog[i].we), 32'(sb_we[i]));
                chk("sb_data", wlog[i].d, sb_d[i]);
            end
        end

        // SH / SW
        wlog.delete();
        store(SH, 32'h202, 32'hBEEF0000);
        store(SW, 32'h300, 32'h12345678);
        StoreValid = 1'b0;
        wait_writes(2, "shsw_write_count");
        if (wlog.size() >= 2) begin
            chk("sh_addr", wlog[0].a, 32'h200);
            chk("sh_we", 32'(wlog[0].we), 32'h3);
            chk("sh_data", wlog[0].d, 32'h0000BEEF);
            chk("sw_addr", wlog[1].a, 32'h300);
            chk("sw_we", 32'(wlog[1].we), 32'hF);
            chk("sw_data", wlog[1].d, 32'h12345678);
        end

        // Misaligned stores
        step();
        errs = 0; req_seen = 1'b0; ne_seen = 1'b0;
        store(SW, 32'h301, 32'hDEADBEEF);
        errs += int'(AlignErr); req_seen |= MemReq; ne_seen |= !BufEmpty;
        store(SH, 32'h203, 32'hCAFE0000);
        errs += int'(AlignErr); req_seen |= MemReq; ne_seen |= !BufEmpty;
        StoreValid = 1'b0;
        repeat (3) begin
            step();
            errs += int'(AlignErr); req_seen |= MemReq; ne_seen |= !BufEmpty;
        end
        chk("misalign_pulses", 32'(errs), 32'd2);
        chk("misalign_memreq", 32'(req_seen), 32'd0);
        chk("misalign_bufempty_drop", 32'(ne_seen), 32'd0);

        // Full / stall
        MemAck = 1'b0;
        wlog.delete();
        store(SW, 32'h400, 32'h11111111);
        store(SW, 32'h404, 32'h22222222);
        chk("stall_full", 32'(StoreStall), 32'd1);
        store(SW, 32'h408, 32'h33333333);
        chk("stall_held1", 32'(StoreStall), 32'd1);
        step();
        chk("stall_held2", 32'(StoreStall), 32'd1);
        MemAck = 1'b1;
        step();
        MemAck = 1'b0;
        chk("stall_release", 32'(StoreStall), 32'd0);
        step();
        StoreValid = 1'b0;
        chk("stall_third_in", 32'(StoreStall), 32'd1);
        MemAck = 1'b1;
        wait_writes(3, "full_write_count");
        if (wlog.size() >= 3) begin
            chk("full_order0", wlog[0].a, 32'h400);
            chk("full_order1", wlog[1].a, 32'h404);
            chk("full_order2", wlog[2].a, 32'h408);
            chk("full_data2", wlog[2].d, 32'h33333333);
        end

        // Held handshake
        MemAck = 1'b0;
        step();
        wlog.delete();
        store(SW, 32'h500, 32'hCAFEF00D);
        StoreValid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("held_req", 32'(MemReq), 32'd1);
            chk("held_addr", MemAddr, 32'h500);
            chk("held_data", MemWrData, 32'hCAFEF00D);
            chk("held_we", 32'(MemWE), 32'hF);
            step();
        end
        MemAck = 1'b1;
        step();
        MemAck = 1'b0;
        chk("held_retired", 32'(wlog.size()), 32'd1);
        chk("held_bufempty", 32'(BufEmpty), 32'd1);

        // Reset mid-drain
        wlog.delete();
        store(SW, 32'h600, 32'h66666666);
        store(SW, 32'h604, 32'h77777777);
        StoreValid = 1'b0;
        chk("rstmid_req_before", 32'(MemReq), 32'd1);
        rst = 1'b1;
        MemAck = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_memreq", 32'(MemReq), 32'd0);
        chk("rstmid_bufempty", 32'(BufEmpty), 32'd1);
        chk("rstmid_stall", 32'(StoreStall), 32'd0);
        repeat (5) step();
        chk("rstmid_no_writes", 32'(wlog.size()), 32'd0);

        // Randomized traffic, checked every cycle by the compare process
        for (int c = 0; c < 3000; c++) begin
            if (c % 500 == 0) ack_pct = $urandom_range(90, 10);
            StoreValid = ($urandom_range(3, 0) != 0);
            case ($urandom_range(7, 0))
                0, 1:    Opcode = SB;
                2, 3:    Opcode = SH;
                4, 5:    Opcode = SW;
                6:       Opcode = 6'h23;
                default: Opcode = 6'($urandom());
            endcase
            Addr         = $urandom();
            DataInMasked = $urandom();
            MemAck       = ($urandom_range(99, 0) < ack_pct);
            rst          = ($urandom_range(499, 0) == 0);
            step();
        end

        rst = 1'b0;
        StoreValid = 1'b0;
        MemAck = 1'b1;
        for (int k = 0; k < 20 && !BufEmpty; k++) step();
        chk("final_drain", 32'(BufEmpty), 32'd1);
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
